reservation_station: RTL and testbench
======================================

# reservation_station

Buffers decoded non-memory instructions (arithmetic, LUI/AUIPC, JAL/JALR, branches) between the decoder and the ALU. Holds each instruction until both source operands are available, snooping the two common data buses (ALU result, load/store result) to resolve renamed operands. Issues at most one ready instruction per cycle to the single-cycle ALU. Flushes on branch misprediction.

## Interface
- `RS_WIDTH`, default 3: log2 of entry count (8 entries).
- `ROB_WIDTH`, default `` `ROB_WIDTH ``: ROB index width.
- `clk_in`, in, 1: clock.
- `rst_in`, in, 1: synchronous, active-high reset.
- `rdy_in`, in, 1: global enable; low means hold all state.
- `flush`, in, 1: misprediction flush.
- `inst_rdy`, in, 1: decoder presents one instruction this cycle.
- `inst_type`, in, 5: operation code.
- `inst_data_j`, `inst_data_k`, in, 32 each: operand values when not pending.
- `inst_pending_j`, `inst_pending_k`, in, 1 each: operand awaits a ROB result.
- `inst_dependency_j`, `inst_dependency_k`, in, ROB_WIDTH each: producer ROB ids.
- `inst_rob_id`, in, ROB_WIDTH: destination ROB id.
- `inst_imm`, in, 32: immediate.
- `rs_full`, out, 1: no entry can accept an instruction.
- `alu_cdb_rdy`, in, 1; `alu_cdb_rob_id`, in, ROB_WIDTH; `alu_cdb_value`, in, 32: ALU broadcast.
- `lsb_cdb_rdy`, in, 1; `lsb_cdb_rob_id`, in, ROB_WIDTH; `lsb_cdb_value`, in, 32: load/store broadcast.
- `alu_rdy`, out, 1: issue valid.
- `alu_type`, out, 5: operation code.
- `alu_op_j`, `alu_op_k`, `alu_imm`, out, 32 each: operands and immediate.
- `alu_rob_id`, out, ROB_WIDTH: destination ROB id.

## Operation
- Each entry holds: valid, type, data_j/k, pending_j/k, dependency_j/k, rob_id, imm.
- Insert: on `inst_rdy`, write into the lowest-index invalid entry.
  - Before storing, each pending operand is checked against both CDBs in the same cycle. On an id match, store the CDB value and clear pending. The ALU bus takes precedence if both buses match.
  - Insert while full is a protocol violation: the instruction is dropped, and the bench asserts this never happens.
- Wakeup: every valid entry whose pending operand dependency matches a valid CDB id captures the value and clears pending.
- Issue:
  - Ready means valid and neither operand pending, evaluated on the registered state at cycle start.
  - Each cycle, the lowest-index ready entry is selected. It is copied to the `alu_*` registers with `alu_rdy` <= 1, and its valid bit is cleared on the same edge.
  - If no entry is ready, `alu_rdy` <= 0.
- Insert and issue in the same cycle are independent. A freed slot is not reusable until the next cycle.
- `rs_full` (combinational) = all entries valid, or (exactly one invalid and `inst_rdy`).
- Flush:
  - All valid bits clear and `alu_rdy` <= 0 on that edge.
  - `inst_rdy` and CDB inputs during a flush cycle are ignored.
  - Flush has priority over insert, wakeup and issue.
- `rdy_in` low: no state change, and registered outputs hold. Reset has priority over `rdy_in` and flush.

## Timing
- Reset values: all entries invalid, `alu_rdy` = 0, `alu_type`/`alu_op_j`/`alu_op_k`/`alu_imm`/`alu_rob_id` = 0, and `rs_full` = 0.
- Minimum latency from `inst_rdy` (both operands ready) to `alu_rdy` is 1 cycle. Outputs are visible after the next edge.
- An entry woken at edge t becomes eligible for issue at the cycle following t, so `alu_rdy` is asserted after edge t+1.
- An operand forwarded at insert behaves identically to one that was ready on arrival.
- `alu_rdy` is a one-cycle pulse per issued instruction. There is no back-pressure, because the ALU accepts every cycle.

## Structure
- Constants `` `RS_WIDTH ``, `` `ROB_WIDTH `` and the 5-bit ALU op encodings live in `params.v`.
- One sub-module, `rs_priority_select`: a combinational lowest-index finder parameterised on width. It is instantiated twice, once over ready bits (issue) and once over free bits (insert), and each instance returns an index plus a found flag.

## Test plan
- Reset, then insert an ADD with j=5, k=7, both ready. After the next edge: `alu_rdy`=1, op_j=5, op_k=7, rob_id as given. One cycle later, `alu_rdy`=0.
- Insert with pending_j on ROB 3. Pulse `lsb_cdb` id 3, value 0x1234 two cycles later. Issue follows 2 edges after the CDB with op_j=0x1234.
- Insert with pending_k on ROB 6 in the same cycle as an `alu_cdb` broadcast of id 6, value 9. The entry issues next cycle with op_k=9 and is never stuck.
- Fill 8 pending entries. Check `rs_full`=1 and that it drops on the cycle after a wakeup-driven issue. Check issue order by lowest index when 3 entries wake simultaneously.
- Fill 5 entries, assert flush alongside `inst_rdy` and a matching CDB. Afterwards all entries are invalid, `alu_rdy`=0, and the new instruction is absent.
- Hold `rdy_in` low for 3 cycles with a ready entry and a CDB pulse. Nothing changes; issue resumes once `rdy_in` rises.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths and ALU op encodings
package reservation_station_pkg;
    localparam int RS_WIDTH_DEF  = 3;
    localparam int ROB_WIDTH_DEF = 4;
    localparam int OP_WIDTH      = 5;
    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
    } alu_op_e;
endpackage

// File: rtl/reservation_station_select.sv
// rs_priority_select: lowest-index set-bit finder with found flag
module rs_priority_select #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? W'(i) : idx_o;
    end
    assign found_o = |req_i;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds ALU-bound instructions until operands resolve, issues one per cycle
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_WIDTH  = RS_WIDTH_DEF,
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 inst_rdy,
    input  logic [OP_WIDTH-1:0]  inst_type,
    input  logic [31:0]          inst_data_j,
    input  logic [31:0]          inst_data_k,
    input  logic                 inst_pending_j,
    input  logic                 inst_pending_k,
    input  logic [ROB_WIDTH-1:0] inst_dependency_j,
    input  logic [ROB_WIDTH-1:0] inst_dependency_k,
    input  logic [ROB_WIDTH-1:0] inst_rob_id,
    input  logic [31:0]          inst_imm,
    output logic                 rs_full,
    input  logic                 alu_cdb_rdy,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_rdy,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]          lsb_cdb_value,
    output logic                 alu_rdy,
    output logic [OP_WIDTH-1:0]  alu_type,
    output logic [31:0]          alu_op_j,
    output logic [31:0]          alu_op_k,
    output logic [31:0]          alu_imm,
    output logic [ROB_WIDTH-1:0] alu_rob_id
);
    localparam int N = 1 << RS_WIDTH;

    typedef struct packed {
        logic [OP_WIDTH-1:0]  op;
        logic [31:0]          dj;
        logic [31:0]          dk;
        logic                 pj;
        logic                 pk;
        logic [ROB_WIDTH-1:0] qj;
        logic [ROB_WIDTH-1:0] qk;
        logic [ROB_WIDTH-1:0] rob;
        logic [31:0]          imm;
    } entry_t;

    typedef struct packed {
        logic                 rdy;
        logic [ROB_WIDTH-1:0] id;
        logic [31:0]          val;
    } cdb_t;

    entry_t               ent_q [N];
    entry_t               ent_d [N];
    entry_t               new_ent;
    logic [N-1:0]         valid_q, valid_d, ready;
    logic [RS_WIDTH-1:0]  iss_idx, ins_idx;
    logic                 iss_found, ins_found;
    logic                 alu_rdy_q, alu_rdy_d;
    logic [OP_WIDTH-1:0]  alu_type_q, alu_type_d;
    logic [31:0]          alu_op_j_q, alu_op_j_d, alu_op_k_q, alu_op_k_d, alu_imm_q, alu_imm_d;
    logic [ROB_WIDTH-1:0] alu_rob_id_q, alu_rob_id_d;
    cdb_t                 alu_cdb, lsb_cdb;

    assign alu_cdb = '{alu_cdb_rdy, alu_cdb_rob_id, alu_cdb_value};
    assign lsb_cdb = '{lsb_cdb_rdy, lsb_cdb_rob_id, lsb_cdb_value};

    // Returns {pending, data}; the ALU bus wins when both buses carry the awaited id
    function automatic logic [32:0] snoop(input logic p, input logic [ROB_WIDTH-1:0] q,
                                          input logic [31:0] d, input cdb_t a, input cdb_t l);
        return !p ? {1'b0, d} :
               (a.rdy && a.id == q) ? {1'b0, a.val} :
               (l.rdy && l.id == q) ? {1'b0, l.val} : {1'b1, d};
    endfunction

    // An entry may issue once valid with both operands already captured
    always_comb begin
        for (int i = 0; i < N; i++) ready[i] = valid_q[i] & ~ent_q[i].pj & ~ent_q[i].pk;
    end

    rs_priority_select #(.N(N)) u_issue_sel (
        .req_i   (ready),
        .idx_o   (iss_idx),
        .found_o (iss_found)
    );

    rs_priority_select #(.N(N)) u_free_sel (
        .req_i   (~valid_q),
        .idx_o   (ins_idx),
        .found_o (ins_found)
    );

    assign rs_full = &valid_q | ($onehot(~valid_q) & inst_rdy);

    // Next state: flush wins; otherwise wakeup, issue and insert touch disjoint entries
    always_comb begin
        valid_d      = valid_q;
        ent_d        = ent_q;
        alu_rdy_d    = 1'b0;
        alu_type_d   = alu_type_q;
        alu_op_j_d   = alu_op_j_q;
        alu_op_k_d   = alu_op_k_q;
        alu_imm_d    = alu_imm_q;
        alu_rob_id_d = alu_rob_id_q;
        new_ent      = '{inst_type, inst_data_j, inst_data_k, inst_pending_j, inst_pending_k,
                         inst_dependency_j, inst_dependency_k, inst_rob_id, inst_imm};
        {new_ent.pj, new_ent.dj} = snoop(inst_pending_j, inst_dependency_j, inst_data_j, alu_cdb, lsb_cdb);
        {new_ent.pk, new_ent.dk} = snoop(inst_pending_k, inst_dependency_k, inst_data_k, alu_cdb, lsb_cdb);
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid_q[i]) begin
                    {ent_d[i].pj, ent_d[i].dj} = snoop(ent_q[i].pj, ent_q[i].qj, ent_q[i].dj, alu_cdb, lsb_cdb);
                    {ent_d[i].pk, ent_d[i].dk} = snoop(ent_q[i].pk, ent_q[i].qk, ent_q[i].dk, alu_cdb, lsb_cdb);
                end
            end
            if (iss_found) begin
                alu_rdy_d         = 1'b1;
                alu_type_d        = ent_q[iss_idx].op;
                alu_op_j_d        = ent_q[iss_idx].dj;
                alu_op_k_d        = ent_q[iss_idx].dk;
                alu_imm_d         = ent_q[iss_idx].imm;
                alu_rob_id_d      = ent_q[iss_idx].rob;
                valid_d[iss_idx]  = 1'b0;
            end
            if (inst_rdy && ins_found) begin
                valid_d[ins_idx] = 1'b1;
                ent_d[ins_idx]   = new_ent;
            end
        end
    end

    // State registers; rdy_in low freezes everything except reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            for (int i = 0; i < N; i++) ent_q[i] <= '0;
            alu_rdy_q    <= 1'b0;
            alu_type_q   <= '0;
            alu_op_j_q   <= '0;
            alu_op_k_q   <= '0;
            alu_imm_q    <= '0;
            alu_rob_id_q <= '0;
        end else if (rdy_in) begin
            valid_q      <= valid_d;
            for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
            alu_rdy_q    <= alu_rdy_d;
            alu_type_q   <= alu_type_d;
            alu_op_j_q   <= alu_op_j_d;
            alu_op_k_q   <= alu_op_k_d;
            alu_imm_q    <= alu_imm_d;
            alu_rob_id_q <= alu_rob_id_d;
        end
    end

    assign alu_rdy    = alu_rdy_q;
    assign alu_type   = alu_type_q;
    assign alu_op_j   = alu_op_j_q;
    assign alu_op_k   = alu_op_k_q;
    assign alu_imm    = alu_imm_q;
    assign alu_rob_id = alu_rob_id_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed stimulus checked against a slot-level behavioural model
module tb_reservation_station;
    import reservation_station_pkg::*;
    localparam int RW = ROB_WIDTH_DEF;

    logic          clk_in = 0, rst_in = 1, rdy_in = 1, flush = 0, inst_rdy = 0;
    logic [4:0]    inst_type = 0;
    logic [31:0]   inst_data_j = 0, inst_data_k = 0, inst_imm = 0;
    logic          inst_pending_j = 0, inst_pending_k = 0;
    logic [RW-1:0] inst_dependency_j = 0, inst_dependency_k = 0, inst_rob_id = 0;
    logic          alu_cdb_rdy = 0, lsb_cdb_rdy = 0;
    logic [RW-1:0] alu_cdb_rob_id = 0, lsb_cdb_rob_id = 0;
    logic [31:0]   alu_cdb_value = 0, lsb_cdb_value = 0;
    logic          rs_full, alu_rdy;
    logic [4:0]    alu_type;
    logic [31:0]   alu_op_j, alu_op_k, alu_imm;
    logic [RW-1:0] alu_rob_id;
    int            checks = 0, errors = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .inst_rdy(inst_rdy),
        .inst_type(inst_type), .inst_data_j(inst_data_j), .inst_data_k(inst_data_k),
        .inst_pending_j(inst_pending_j), .inst_pending_k(inst_pending_k),
        .inst_dependency_j(inst_dependency_j), .inst_dependency_k(inst_dependency_k),
        .inst_rob_id(inst_rob_id), .inst_imm(inst_imm), .rs_full(rs_full),
        .alu_cdb_rdy(alu_cdb_rdy), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_rdy(lsb_cdb_rdy), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .alu_rdy(alu_rdy), .alu_type(alu_type), .alu_op_j(alu_op_j), .alu_op_k(alu_op_k),
        .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        v, pj, pk;
        int        qj, qk, op, rob;
        bit [31:0] dj, dk, imm;
    } slot_t;

    slot_t     m [8];
    bit        e_rdy;
    int        e_op, e_rob;
    bit [31:0] e_j, e_k, e_imm;

    function automatic void snoop(inout bit p, inout bit [31:0] d, input int q);
        if (!p) return;
        if (alu_cdb_rdy && int'(alu_cdb_rob_id) == q) begin d = alu_cdb_value; p = 0; end
        else if (lsb_cdb_rdy && int'(lsb_cdb_rob_id) == q) begin d = lsb_cdb_value; p = 0; end
    endfunction

    always @(negedge clk_in) begin
        int fr, iss, nfree;
        slot_t s;
        nfree = 0;
        for (int i = 0; i < 8; i++) if (!m[i].v) nfree++;
        chk("rs_full", rs_full, 32'(nfree == 0 || (nfree == 1 && inst_rdy)));
        chk("alu_rdy", alu_rdy, 32'(e_rdy));
        chk("alu_type", alu_type, e_op);
        chk("alu_op_j", alu_op_j, e_j);
        chk("alu_op_k", alu_op_k, e_k);
        chk("alu_imm", alu_imm, e_imm);
        chk("alu_rob_id", alu_rob_id, e_rob);
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m[i].v = 0;
            e_rdy = 0; e_op = 0; e_j = 0; e_k = 0; e_imm = 0; e_rob = 0;
        end else if (rdy_in && flush) begin
            for (int i = 0; i < 8; i++) m[i].v = 0;
            e_rdy = 0;
        end else if (rdy_in) begin
            iss = -1; fr = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m[i].v && !m[i].pj && !m[i].pk) iss = i;
                if (!m[i].v) fr = i;
            end
            chk("insert_while_full", 32'(inst_rdy && fr < 0), 0);
            e_rdy = iss >= 0;
            if (iss >= 0) begin
                e_op = m[iss].op; e_j = m[iss].dj; e_k = m[iss].dk;
                e_imm = m[iss].imm; e_rob = m[iss].rob; m[iss].v = 0;
            end
            for (int i = 0; i < 8; i++) if (m[i].v) begin
                snoop(m[i].pj, m[i].dj, m[i].qj);
                snoop(m[i].pk, m[i].dk, m[i].qk);
            end
            if (inst_rdy && fr >= 0) begin
                s.v = 1; s.op = int'(inst_type); s.rob = int'(inst_rob_id); s.imm = inst_imm;
                s.pj = inst_pending_j; s.dj = inst_data_j; s.qj = int'(inst_dependency_j);
                s.pk = inst_pending_k; s.dk = inst_data_k; s.qk = int'(inst_dependency_k);
                snoop(s.pj, s.dj, s.qj);
                snoop(s.pk, s.dk, s.qk);
                m[fr] = s;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        inst_rdy = 0; alu_cdb_rdy = 0; lsb_cdb_rdy = 0; flush = 0;
    endtask

    task automatic ins(input int op, input bit [31:0] dj, input bit [31:0] dk,
                       input bit pj, input bit pk, input int qj, input int qk, input int rob);
        inst_rdy = 1; inst_type = op[4:0]; inst_data_j = dj; inst_data_k = dk;
        inst_pending_j = pj; inst_pending_k = pk;
        inst_dependency_j = qj[RW-1:0]; inst_dependency_k = qk[RW-1:0];
        inst_rob_id = rob[RW-1:0]; inst_imm = 32'h1000 + 32'(rob);
    endtask

    task automatic alu_bc(input int id, input bit [31:0] v);
        alu_cdb_rdy = 1; alu_cdb_rob_id = id[RW-1:0]; alu_cdb_value = v;
    endtask

    task automatic lsb_bc(input int id, input bit [31:0] v);
        lsb_cdb_rdy = 1; lsb_cdb_rob_id = id[RW-1:0]; lsb_cdb_value = v;
    endtask

    int deps [8] = '{8, 9, 12, 10, 11, 12, 13, 12};

    initial begin
        tick(); tick();
        rst_in = 0;
        chk("reset_alu_rdy", alu_rdy, 0);
        chk("reset_rs_full", rs_full, 0);
        chk("reset_op_j", alu_op_j, 0);
        ins(OP_ADD, 5, 7, 0, 0, 0, 0, 2); tick(); idle();
        chk("add_not_yet", alu_rdy, 0);
        tick();
        chk("add_rdy", alu_rdy, 1); chk("add_j", alu_op_j, 5); chk("add_k", alu_op_k, 7);
        chk("add_rob", alu_rob_id, 2); chk("add_imm", alu_imm, 32'h1002);
        tick();
        chk("add_pulse", alu_rdy, 0);
        ins(OP_SUB, 0, 1, 1, 0, 3, 0, 4); tick(); idle();
        tick();
        lsb_bc(3, 32'h1234); tick(); idle();
        chk("wake_not_yet", alu_rdy, 0);
        tick();
        chk("wake_rdy", alu_rdy, 1); chk("wake_j", alu_op_j, 32'h1234); chk("wake_rob", alu_rob_id, 4);
        tick();
        ins(OP_XOR, 2, 0, 0, 1, 0, 6, 5); alu_bc(6, 9); tick(); idle();
        tick();
        chk("fwd_rdy", alu_rdy, 1); chk("fwd_k", alu_op_k, 9); chk("fwd_j", alu_op_j, 2);
        tick();
        ins(OP_AND, 0, 0, 1, 0, 7, 0, 6); alu_bc(7, 32'hA); lsb_bc(7, 32'hB); tick(); idle();
        tick();
        chk("both_bus_alu_wins", alu_op_j, 32'hA);
        tick();
        for (int i = 0; i < 8; i++) begin
            ins(OP_OR, 32'(i), 0, 1, 0, deps[i], 0, i);
            #1;
            if (i == 6) chk("two_free_not_full", rs_full, 0);
            if (i == 7) chk("last_free_full", rs_full, 1);
            tick();
        end
        idle(); #1;
        chk("all_valid_full", rs_full, 1);
        alu_bc(12, 32'h77); tick(); idle();
        chk("full_after_wake", rs_full, 1);
        tick();
        chk("order_first", alu_rob_id, 2); chk("order_val", alu_op_j, 32'h77);
        chk("full_drops", rs_full, 0);
        tick(); chk("order_second", alu_rob_id, 5);
        tick(); chk("order_third", alu_rob_id, 7);
        tick(); chk("order_done", alu_rdy, 0);
        ins(OP_ADD, 1, 1, 0, 0, 0, 0, 14); tick();
        ins(OP_AND, 3, 3, 0, 0, 0, 0, 15); flush = 1; alu_bc(8, 32'h55); tick(); idle();
        chk("flush_no_issue", alu_rdy, 0);
        tick(); chk("flush_new_absent", alu_rdy, 0);
        alu_bc(9, 1); lsb_bc(10, 2); tick(); idle();
        tick(); tick(); chk("flush_no_wake", alu_rdy, 0); chk("flush_empty", rs_full, 0);
        ins(OP_SLT, 0, 0, 1, 0, 15, 0, 3); tick();
        ins(OP_ADD, 3, 4, 0, 0, 0, 0, 1); tick(); idle();
        rdy_in = 0; lsb_bc(15, 32'hAB); tick(); idle();
        tick(); tick();
        chk("hold_no_issue", alu_rdy, 0);
        rdy_in = 1; tick();
        chk("resume_rdy", alu_rdy, 1); chk("resume_rob", alu_rob_id, 1); chk("resume_j", alu_op_j, 3);
        tick(); chk("held_cdb_ignored", alu_rdy, 0);
        lsb_bc(15, 32'hAB); tick(); idle();
        tick();
        chk("late_wake_rob", alu_rob_id, 3); chk("late_wake_j", alu_op_j, 32'hAB);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
